// File: rtl/kbd_pkg.sv
// Shared constants and types for the PS/2 keyboard event controller:
// scan-code prefixes, shift keys, FSM states and the queued event record.
package kbd_pkg;

    localparam logic [7:0] SC_EXT    = 8'hE0;
    localparam logic [7:0] SC_BREAK  = 8'hF0;
    localparam logic [7:0] SC_LSHIFT = 8'h12;
    localparam logic [7:0] SC_RSHIFT = 8'h59;

    typedef struct packed {
        logic [7:0] code;
        logic       brk;
        logic       ext;
    } kbd_evt_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        ACK     = 2'd2
    } kbd_state_t;

endpackage

// File: rtl/kbd_evt_fifo.sv
// Show-ahead event FIFO: the head entry is visible on o_head while not empty.
// A push while full is accepted only if a pop happens in the same cycle.
module kbd_evt_fifo
    import kbd_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clock50,
    input  logic                          reset,
    input  logic                          i_push,
    input  kbd_evt_t                      i_data,
    input  logic                          i_pop,
    output kbd_evt_t                      o_head,
    output logic                          o_full,
    output logic                          o_empty,
    output logic [$clog2(FIFO_DEPTH):0]   o_count
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW-1:0] PTR_ONE = 1;
    localparam logic [AW:0]   CNT_ONE = 1;
    localparam logic [AW:0]   CNT_FULL = FIFO_DEPTH;

    kbd_evt_t        r_mem [FIFO_DEPTH];
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [AW:0]     r_count;
    logic            w_pop;
    logic            w_push_ok;

    assign o_empty   = (r_count == '0);
    assign o_full    = (r_count == CNT_FULL);
    assign o_count   = r_count;
    assign o_head    = r_mem[r_rd_ptr];
    assign w_pop     = i_pop && !o_empty;
    // The slot freed by a same-cycle pop makes room for the push.
    assign w_push_ok = i_push && (!o_full || w_pop);

    always_ff @(posedge clock50) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + PTR_ONE;
            if (w_pop)     r_rd_ptr <= r_rd_ptr + PTR_ONE;
            case ({w_push_ok, w_pop})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clock50) begin
        if (w_push_ok) r_mem[r_wr_ptr] <= i_data;
    end

endmodule

// File: rtl/kbd_event_ctrl.sv
// PS/2 scan-code handshake, prefix decoder, shift tracker and event queue.
// Converts raw scan codes into {code, break, extended} events for a consumer.
module kbd_event_ctrl
    import kbd_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clock50,
    input  logic       reset,
    input  logic       scan_ready,
    input  logic [7:0] scan_code,
    output logic       read,
    output logic       evt_valid,
    output logic [7:0] evt_code,
    output logic       evt_break,
    output logic       evt_ext,
    input  logic       evt_ack,
    output logic       shift_held,
    output logic       overflow
);

    kbd_state_t                  r_state;
    kbd_state_t                  w_state_next;
    logic                        r_sync1;
    logic                        r_rdy_s;
    logic                        r_ext_pend;
    logic                        r_brk_pend;
    logic                        r_lshift;
    logic                        r_rshift;
    logic                        r_shift_held;
    logic                        r_overflow;
    logic                        w_capture;
    logic                        w_is_ext;
    logic                        w_is_brk;
    logic                        w_push;
    logic                        w_pop;
    logic                        w_full;
    logic                        w_empty;
    logic [$clog2(FIFO_DEPTH):0] w_count;
    kbd_evt_t                    w_evt_in;
    kbd_evt_t                    w_head;

    always_ff @(posedge clock50) begin
        if (reset) begin
            r_sync1 <= 1'b0;
            r_rdy_s <= 1'b0;
        end else begin
            r_sync1 <= scan_ready;
            r_rdy_s <= r_sync1;
        end
    end

    always_ff @(posedge clock50) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_state_next;
    end

    // ACK holds until the receiver drops scan_ready, so one code is captured once.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (r_rdy_s) w_state_next = CAPTURE;
            CAPTURE: w_state_next = ACK;
            ACK:     if (!r_rdy_s) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    assign read      = (r_state == ACK);
    assign w_capture = (r_state == CAPTURE);
    assign w_is_ext  = (scan_code == SC_EXT);
    assign w_is_brk  = (scan_code == SC_BREAK);
    assign w_push    = w_capture && !w_is_ext && !w_is_brk;
    assign w_evt_in  = '{code: scan_code, brk: r_brk_pend, ext: r_ext_pend};

    always_ff @(posedge clock50) begin
        if (reset) begin
            r_ext_pend <= 1'b0;
            r_brk_pend <= 1'b0;
        end else if (w_capture) begin
            if (w_is_ext) begin
                r_ext_pend <= 1'b1;
            end else if (w_is_brk) begin
                r_brk_pend <= 1'b1;
            end else begin
                r_ext_pend <= 1'b0;
                r_brk_pend <= 1'b0;
            end
        end
    end

    // Extended 0x12/0x59 are different keys, so only plain codes move shift state.
    always_ff @(posedge clock50) begin
        if (reset) begin
            r_lshift     <= 1'b0;
            r_rshift     <= 1'b0;
            r_shift_held <= 1'b0;
        end else begin
            if (w_push && !r_ext_pend) begin
                if (scan_code == SC_LSHIFT) r_lshift <= !r_brk_pend;
                if (scan_code == SC_RSHIFT) r_rshift <= !r_brk_pend;
            end
            r_shift_held <= r_lshift | r_rshift;
        end
    end

    assign w_pop = evt_ack && !w_empty;

    always_ff @(posedge clock50) begin
        if (reset)                          r_overflow <= 1'b0;
        else if (w_push && w_full && !w_pop) r_overflow <= 1'b1;
    end

    kbd_evt_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock50 (clock50),
        .reset   (reset),
        .i_push  (w_push),
        .i_data  (w_evt_in),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    // Storage is not reset, so the head fields are masked while nothing is queued.
    assign evt_valid  = (w_count != '0);
    assign evt_code   = evt_valid ? w_head.code : 8'h00;
    assign evt_break  = evt_valid ? w_head.brk  : 1'b0;
    assign evt_ext    = evt_valid ? w_head.ext  : 1'b0;
    assign shift_held = r_shift_held;
    assign overflow   = r_overflow;

endmodule

// File: doc/kbd_event_ctrl.md
KBD_EVENT_CTRL -- requirements
Module: kbd_event_ctrl

Interface
REQ-001 Parameter: FIFO_DEPTH, 4, number of event FIFO entries (power of two, minimum 2).
REQ-002 clock50  in  1  50 MHz system clock; all logic SHALL be on its rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 scan_ready  in  1  from the PS/2 receiver; asynchronous to clock50; high while scan_code is valid.
REQ-005 scan_code  in  8  from the PS/2 receiver; stable while scan_ready is high.
REQ-006 read  out  1  to the PS/2 receiver; a rising edge clears scan_ready.
REQ-007 evt_valid  out  1  FIFO head holds an event.
REQ-008 evt_code  out  8  scan code of the head event.
REQ-009 evt_break  out  1  head event is a key release (F0-prefixed).
REQ-010 evt_ext  out  1  head event is an extended key (E0-prefixed).
REQ-011 evt_ack  in  1  consumer pops the head when evt_valid and evt_ack are both high.
REQ-012 shift_held  out  1  left or right Shift is currently pressed.
REQ-013 overflow  out  1  sticky flag: an event was dropped because the FIFO was full.

Function
REQ-014 scan_ready SHALL pass through a 2-flop synchronizer (rdy_s) before any use.
REQ-015 Handshake FSM states SHALL be IDLE, CAPTURE and ACK.
- IDLE: rdy_s=1 -> CAPTURE.
- CAPTURE: register scan_code and decode it; -> ACK.
- ACK: read=1; rdy_s=0 -> IDLE.
REQ-016 read SHALL be high only in ACK and low in every other state.
REQ-017 The FSM SHALL never re-enter CAPTURE for the same code; after ACK it returns to IDLE only after rdy_s=0.
REQ-018 Decode of code E0 SHALL set ext_pend and push nothing.
REQ-019 Decode of code F0 SHALL set brk_pend and push nothing.
REQ-020 Prefix order SHALL be accepted either way: E0 F0 x and F0 E0 x both give ext=1, brk=1.
REQ-021 Decode of any other code SHALL push {code, brk_pend, ext_pend} into the FIFO in the CAPTURE cycle, then clear both pend flags.
REQ-022 Shift tracking SHALL apply only to non-extended codes:
- 0x12 sets lshift on make and clears it on break.
- 0x59 does the same for rshift.
- shift_held = lshift OR rshift, registered.
REQ-023 FIFO SHALL be show-ahead: evt_* SHALL reflect the head whenever evt_valid=1.
REQ-024 With an empty FIFO, evt_valid SHALL rise exactly 4 clock50 edges after scan_ready rises, for a non-prefix code (2 sync, 1 IDLE->CAPTURE, 1 push).
REQ-025 A push to a full FIFO with no simultaneous pop SHALL drop the event and set overflow; overflow SHALL stay high until reset.
REQ-026 Simultaneous push and pop on a full FIFO SHALL accept both, with no overflow.
REQ-027 Simultaneous push and pop on an empty FIFO SHALL take the push; evt_ack is ignored while evt_valid=0.
REQ-028 FIFO pointers SHALL wrap modulo FIFO_DEPTH; occupancy SHALL be held in a counter of width clog2(FIFO_DEPTH)+1.
REQ-029 Event order SHALL be preserved end to end.

Reset
REQ-030 On reset, the FSM SHALL go to IDLE and these SHALL clear to 0:
- read, evt_valid, shift_held, overflow;
- ext_pend, brk_pend, lshift, rshift;
- synchronizer flops;
- FIFO pointers and count.
REQ-031 evt_code, evt_break and evt_ext SHALL read 0 after reset.
REQ-032 Reset asserted mid-handshake (ACK) SHALL drop read in the next cycle. Any pending prefix SHALL be discarded.
REQ-033 After reset releases, the FSM SHALL capture a still-high scan_ready as a new code.

Structure
REQ-034 Shared package kbd_pkg SHALL hold:
- SC_EXT=8'hE0, SC_BREAK=8'hF0, SC_LSHIFT=8'h12, SC_RSHIFT=8'h59;
- the 10-bit event record type {code, brk, ext}.
REQ-035 Sub-module kbd_evt_fifo SHALL implement the parameterized show-ahead FIFO with push, pop, full, empty and count.
REQ-036 Synchronizer, FSM and decoder SHALL live in kbd_event_ctrl; target size is 150-300 lines of RTL.

Verification
REQ-037 Single make: scan_code 0x1C, scan_ready pulse, consumer idle -> evt_valid at edge 4, evt_code=0x1C, brk=0, ext=0, read high until rdy_s low.
REQ-038 Extended break: sequence E0, F0, 0x75 -> exactly one event {0x75, brk=1, ext=1}; prefixes produce no events.
REQ-039 Shift tracking: codes 12, 59, F0 12 -> shift_held goes 1, stays 1 after the left release, then goes 0 after F0 59. E0 12 leaves shift_held unchanged.
REQ-040 Overflow: with evt_ack=0, send 5 codes (FIFO_DEPTH=4) -> first 4 retained in order, 5th dropped, overflow=1 until reset.
REQ-041 Full FIFO with push and pop in the same cycle -> count stays 4, overflow stays 0, new code appears last.
REQ-042 Reset asserted during ACK after an F0 prefix -> read=0 next cycle, FIFO empty. The next code 0x1C yields brk=0.
